encoder_with_control: RTL and testbench
=======================================

Name: encoder_with_control

Overview:
- Width-halving serializer; the transmit-side counterpart of the two-beat decoder.
- Accepts one double-width word of 2*no_of_units elements and emits it as two consecutive single-width beats of no_of_units elements each.
- Sits between a cluster result register and the narrow element bus.
- Supports downstream back-pressure and back-to-back loads without bubbles.

Parameters:
- no_of_units, 4, elements per narrow beat
- element_width, 32, bits per element

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in  input  2*element_width*no_of_units  double-width word to serialize
- encoder_load  input  1  load strobe; word on in is captured when encoder_load && load_ready
- load_ready  output  1  block can accept a word this cycle (combinational from state and outsider_read_now)
- out  output  element_width*no_of_units  current narrow beat (registered)
- out_valid  output  1  out holds a valid beat
- outsider_read_now  input  1  downstream accepts the beat this cycle; a transfer is out_valid && outsider_read_now
- beat_is_last  output  1  current beat is the second half of its word
- word_done  output  1  one-cycle pulse, registered, the cycle after a second-beat transfer

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - out=0, out_valid=0, beat_is_last=0, word_done=0.
  - Internal hold register cleared.
- Let H = element_width*no_of_units. Low half = in[H-1:0]; high half = in[2H-1:H].
- States:
  - IDLE: out_valid=0; load_ready=1.
    - On load: capture in into the hold register.
    - Next cycle: out=low half, out_valid=1, beat_is_last=0. Go to FIRST.
  - FIRST: out_valid=1; load_ready=0.
    - On transfer: next cycle out=high half, beat_is_last=1. Go to SECOND.
    - No transfer: hold out and state unchanged.
  - SECOND: out_valid=1; load_ready=outsider_read_now.
    - Transfer with simultaneous load: next cycle out=low half of the new word, beat_is_last=0, hold register updated. Go to FIRST. Zero-bubble back-to-back.
    - Transfer without load: next cycle out_valid=0. Go to IDLE.
    - No transfer: hold out and state unchanged.
- Latency: load at edge t gives first beat valid after edge t. Minimum two cycles per word; one word per two cycles sustained.
- word_done asserts for exactly one cycle after every second-beat transfer, including back-to-back words.
- encoder_load while load_ready=0 is ignored: no capture, no error, in not sampled.
- out and beat_is_last are stable whenever out_valid=1 and outsider_read_now=0.
- Reset asserted mid-word discards the remaining beat. After release the block is in IDLE and accepts a new load on the first edge.
- No width arithmetic beyond slicing; element order within a half is preserved bit-for-bit.

Optional Feature:
- Macro: ENCODER_HIGH_FIRST_EN.
- Defined: beat order is swapped. The first beat is in[2H-1:H] and the second (beat_is_last=1) is in[H-1:0]. This matches a receiver whose select starts at the upper half.
- Undefined: low half first, as described above.
- Handshake, latency and word_done are identical in both builds.

Test Plan:
- Reset then single word:
  - Stimulus: in=256'h{8'h11 repeated ×16, 8'h22 repeated ×16} (high=0x11.., low=0x22..), encoder_load pulse, outsider_read_now=1.
  - Response: out=0x22.. with beat_is_last=0, then out=0x11.. with beat_is_last=1; word_done pulses one cycle; out_valid=0 after.
- Back-pressure:
  - Stimulus: outsider_read_now=0 for 5 cycles in FIRST.
  - Response: out held at the low half; load_ready=0; raising outsider_read_now advances to the high half on the next edge.
- Back-to-back:
  - Stimulus: words A, B; load B in the SECOND cycle of A with outsider_read_now=1.
  - Response: beats A.lo, A.hi, B.lo, B.hi on 4 consecutive cycles; word_done pulses twice.
- Ignored load:
  - Stimulus: encoder_load=1 with in=C during FIRST.
  - Response: C never appears on out; the current word completes unchanged.
- Reset mid-word:
  - Stimulus: assert reset asynchronously between clock edges while in SECOND.
  - Response: out_valid=0 and out=0 immediately; after release a new word D serializes as D.lo, D.hi.
- ENCODER_HIGH_FIRST_EN build:
  - Stimulus: repeat the first scenario.
  - Response: 0x11.. first, then 0x22.. with beat_is_last=1.

Source files
------------

// File: rtl/encoder_with_control.sv
// Width-halving serializer: one double-width word in, two narrow beats out.
// Define ENCODER_HIGH_FIRST_EN to emit the upper half first.
module encoder_with_control #(
  parameter int no_of_units   = 4,
  parameter int element_width = 32
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [2*element_width*no_of_units-1:0] in,
  input  logic                                   encoder_load,
  output logic                                   load_ready,
  output logic [element_width*no_of_units-1:0]   out,
  output logic                                   out_valid,
  input  logic                                   outsider_read_now,
  output logic                                   beat_is_last,
  output logic                                   word_done
);

  localparam int H = element_width * no_of_units;

  typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_e;

  state_e         state_q, state_d;
  logic [H-1:0]   hold_q, hold_d;
  logic [H-1:0]   out_q, out_d;
  logic           word_done_q, word_done_d;
  logic [H-1:0]   in_lead, in_trail;
  logic           xfer, load_fire;

`ifdef ENCODER_HIGH_FIRST_EN
  assign in_lead  = in[2*H-1:H];
  assign in_trail = in[H-1:0];
`else
  assign in_lead  = in[H-1:0];
  assign in_trail = in[2*H-1:H];
`endif

  assign xfer      = out_valid && outsider_read_now;
  assign load_fire = encoder_load && load_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (load_fire) state_d = FIRST;
      FIRST:  if (xfer)      state_d = SECOND;
      SECOND: if (xfer)      state_d = load_fire ? FIRST : IDLE;
      default:               state_d = IDLE;
    endcase
  end

  always_comb begin
    load_ready   = 1'b0;
    out_valid    = 1'b0;
    beat_is_last = 1'b0;
    unique case (state_q)
      IDLE:   load_ready = 1'b1;
      FIRST:  out_valid  = 1'b1;
      SECOND: begin
        out_valid    = 1'b1;
        beat_is_last = 1'b1;
        load_ready   = outsider_read_now;
      end
      default: ;
    endcase
  end

  // Only the trailing half needs holding; the leading half goes straight to out.
  always_comb begin
    hold_d      = hold_q;
    out_d       = out_q;
    word_done_d = (state_q == SECOND) && xfer;
    if (load_fire) begin
      hold_d = in_trail;
      out_d  = in_lead;
    end else if ((state_q == FIRST) && xfer) begin
      out_d = hold_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q      <= '0;
      out_q       <= '0;
      word_done_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      out_q       <= out_d;
      word_done_q <= word_done_d;
    end
  end

  assign out       = out_q;
  assign word_done = word_done_q;

endmodule

// File: tb/tb_encoder_with_control.sv
// Directed bench for encoder_with_control; expected beats follow the
// ENCODER_HIGH_FIRST_EN build setting.
module tb_encoder_with_control;

  localparam int H = 128;

  logic           clk;
  logic           reset;
  logic [2*H-1:0] in;
  logic           encoder_load;
  logic           load_ready;
  logic [H-1:0]   out;
  logic           out_valid;
  logic           outsider_read_now;
  logic           beat_is_last;
  logic           word_done;

  int tests_run = 0;
  int tests_failed = 0;

  encoder_with_control dut (
    .clk               (clk),
    .reset             (reset),
    .in                (in),
    .encoder_load      (encoder_load),
    .load_ready        (load_ready),
    .out               (out),
    .out_valid         (out_valid),
    .outsider_read_now (outsider_read_now),
    .beat_is_last      (beat_is_last),
    .word_done         (word_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [H-1:0] first_of(input logic [2*H-1:0] w);
`ifdef ENCODER_HIGH_FIRST_EN
    return w[2*H-1:H];
`else
    return w[H-1:0];
`endif
  endfunction

  function automatic logic [H-1:0] second_of(input logic [2*H-1:0] w);
`ifdef ENCODER_HIGH_FIRST_EN
    return w[H-1:0];
`else
    return w[2*H-1:H];
`endif
  endfunction

  task automatic test_reset();
    reset = 1'b1; in = '0; encoder_load = 1'b0; outsider_read_now = 1'b0;
    @(negedge clk);
    tests_run++;
    if (out !== '0 || out_valid !== 1'b0 || beat_is_last !== 1'b0 || word_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: out=%h valid=%b last=%b done=%b, required all zero", out, out_valid, beat_is_last, word_done);
    end
    tests_run++;
    if (load_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_load_ready: got %b, required 1", load_ready);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_word();
    logic [2*H-1:0] w;
    w = {{16{8'h11}}, {16{8'h22}}};
    in = w; encoder_load = 1'b1; outsider_read_now = 1'b1;
    @(negedge clk);
    encoder_load = 1'b0;
    tests_run++;
    if (out !== first_of(w) || out_valid !== 1'b1 || beat_is_last !== 1'b0 || load_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_beat1: out=%h valid=%b last=%b ready=%b, required out=%h valid=1 last=0 ready=0",
               out, out_valid, beat_is_last, load_ready, first_of(w));
    end
    @(negedge clk);
    tests_run++;
    if (out !== second_of(w) || out_valid !== 1'b1 || beat_is_last !== 1'b1 || word_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_beat2: out=%h valid=%b last=%b done=%b, required out=%h valid=1 last=1 done=0",
               out, out_valid, beat_is_last, word_done, second_of(w));
    end
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || word_done !== 1'b1 || load_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_done: valid=%b done=%b ready=%b, required valid=0 done=1 ready=1", out_valid, word_done, load_ready);
    end
    @(negedge clk);
    tests_run++;
    if (word_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_done_pulse: done=%b, required 0", word_done);
    end
  endtask

  task automatic test_back_pressure();
    logic [2*H-1:0] w;
    w = {{8{16'hA5C3}}, {8{16'h5A3C}}};
    in = w; encoder_load = 1'b1; outsider_read_now = 1'b0;
    @(negedge clk);
    encoder_load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (out !== first_of(w) || out_valid !== 1'b1 || beat_is_last !== 1'b0 || load_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: out=%h valid=%b last=%b ready=%b, required out=%h valid=1 last=0 ready=0",
                 i, out, out_valid, beat_is_last, load_ready, first_of(w));
      end
      if (i == 4) outsider_read_now = 1'b1;
      @(negedge clk);
    end
    tests_run++;
    if (out !== second_of(w) || beat_is_last !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_advance: out=%h last=%b, required out=%h last=1", out, beat_is_last, second_of(w));
    end
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || word_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_done: valid=%b done=%b, required valid=0 done=1", out_valid, word_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [2*H-1:0] a, b;
    a = {{4{32'hAAAA_0001}}, {4{32'hAAAA_0000}}};
    b = {{4{32'hBBBB_0001}}, {4{32'hBBBB_0000}}};
    in = a; encoder_load = 1'b1; outsider_read_now = 1'b1;
    @(negedge clk);
    encoder_load = 1'b0;
    tests_run++;
    if (out !== first_of(a) || beat_is_last !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_a1: out=%h last=%b, required out=%h last=0", out, beat_is_last, first_of(a));
    end
    @(negedge clk);
    tests_run++;
    if (out !== second_of(a) || beat_is_last !== 1'b1 || load_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_a2: out=%h last=%b ready=%b, required out=%h last=1 ready=1", out, beat_is_last, load_ready, second_of(a));
    end
    in = b; encoder_load = 1'b1;
    @(negedge clk);
    encoder_load = 1'b0;
    tests_run++;
    if (out !== first_of(b) || out_valid !== 1'b1 || beat_is_last !== 1'b0 || word_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_b1: out=%h valid=%b last=%b done=%b, required out=%h valid=1 last=0 done=1",
               out, out_valid, beat_is_last, word_done, first_of(b));
    end
    @(negedge clk);
    tests_run++;
    if (out !== second_of(b) || beat_is_last !== 1'b1 || word_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_b2: out=%h last=%b done=%b, required out=%h last=1 done=0", out, beat_is_last, word_done, second_of(b));
    end
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || word_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_done: valid=%b done=%b, required valid=0 done=1", out_valid, word_done);
    end
  endtask

  task automatic test_ignored_load();
    logic [2*H-1:0] w, c;
    w = {{2{64'h0123_4567_89AB_CDEF}}, {2{64'hFEDC_BA98_7654_3210}}};
    c = {{32{8'hCC}}};
    in = w; encoder_load = 1'b1; outsider_read_now = 1'b0;
    @(negedge clk);
    in = c; encoder_load = 1'b1;
    @(negedge clk);
    tests_run++;
    if (out !== first_of(w) || beat_is_last !== 1'b0) begin
      tests_failed++;
      $display("FAIL ign_first: out=%h last=%b, required out=%h last=0", out, beat_is_last, first_of(w));
    end
    outsider_read_now = 1'b1;
    @(negedge clk);
    encoder_load = 1'b0;
    tests_run++;
    if (out !== second_of(w) || beat_is_last !== 1'b1) begin
      tests_failed++;
      $display("FAIL ign_second: out=%h last=%b, required out=%h last=1", out, beat_is_last, second_of(w));
    end
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || word_done !== 1'b1 || out === first_of(c)) begin
      tests_failed++;
      $display("FAIL ign_done: valid=%b done=%b out=%h, required valid=0 done=1 and no C beat", out_valid, word_done, out);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [2*H-1:0] e, d;
    e = {{16{8'hE1}}, {16{8'hE0}}};
    d = {{16{8'hD1}}, {16{8'hD0}}};
    in = e; encoder_load = 1'b1; outsider_read_now = 1'b1;
    @(negedge clk);
    encoder_load = 1'b0;
    @(negedge clk);
    outsider_read_now = 1'b0;
    tests_run++;
    if (beat_is_last !== 1'b1 || out !== second_of(e)) begin
      tests_failed++;
      $display("FAIL rst_pre: out=%h last=%b, required out=%h last=1", out, beat_is_last, second_of(e));
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out !== '0 || beat_is_last !== 1'b0 || load_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_async: out=%h valid=%b last=%b ready=%b, required out=0 valid=0 last=0 ready=1",
               out, out_valid, beat_is_last, load_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    in = d; encoder_load = 1'b1; outsider_read_now = 1'b1;
    @(negedge clk);
    encoder_load = 1'b0;
    tests_run++;
    if (out !== first_of(d) || out_valid !== 1'b1 || beat_is_last !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_d1: out=%h valid=%b last=%b, required out=%h valid=1 last=0", out, out_valid, beat_is_last, first_of(d));
    end
    @(negedge clk);
    tests_run++;
    if (out !== second_of(d) || beat_is_last !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_d2: out=%h last=%b, required out=%h last=1", out, beat_is_last, second_of(d));
    end
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || word_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_done: valid=%b done=%b, required valid=0 done=1", out_valid, word_done);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_pressure();
    test_back_to_back();
    test_ignored_load();
    test_reset_mid_word();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
